npn_tt_scanner: RTL and testbench
=================================

# npn_tt_scanner

Sequential truth-table scanner that drives a 4-input single-output NPN-class function block (ports x0..x3 -> y0) through all 16 minterms. Each minterm passes through a programmable input permutation and input negation, and each response through an optional output negation. The block assembles the resulting 16-bit truth table and compares it against an expected table. It sits directly upstream of the function block, which it feeds, and also consumes that block's output. Its purpose is on-chip self-check of exact-synthesis netlists under arbitrary NPN transforms.

## Interface
- SETTLE, default 0: extra hold cycles per minterm before sampling y0 (0..15); allows for multi-cycle paths through the function block.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a scan; sampled in IDLE only
- perm  input  8  permutation; perm[2j+1:2j] = minterm bit index driving x_j
- neg  input  4  input negation mask; neg[j] inverts x_j
- out_neg  input  1  invert y0 before capture
- exp_tt  input  16  expected truth table
- x0, x1, x2, x3  output  1 each  stimulus to function block
- y0  input  1  function block output, combinational from x0..x3
- busy  output  1  scan in progress
- done  output  1  one-cycle completion pulse
- tt  output  16  captured truth table, bit m = response to minterm m
- match  output  1  tt == exp_tt, valid while done=1 and held until the next start
- err  output  1  last request had an invalid perm

## Operation
- States: IDLE, SCAN, FIN.
- **IDLE**
  - On start=1, latch perm, neg, out_neg and exp_tt; clear tt, match and err.
  - Valid perm: go to SCAN with m=0 and hold counter h=0.
  - Invalid perm (the four 2-bit fields are not all distinct): go to FIN with err=1 and tt=0.
- **SCAN**
  - x_j = m[perm_l[2j+1:2j]] ^ neg_l[j], where _l denotes a latched value.
  - x0..x3 derive only from registers; there is no combinational path from any input port.
  - While h<SETTLE: h++.
  - When h==SETTLE: tt[m] <= y0 ^ out_neg_l; h <= 0; m <= m+1.
  - If m==15 when sampled: go to FIN. The counter is 4 bits; its wrap to 0 is not observed.
- **FIN**
  - done=1 for exactly one cycle.
  - match = (tt_final == exp_tt_l); forced to 0 when err=1.
  - Next state: IDLE.
- busy=1 in SCAN and FIN, 0 in IDLE.
- start while busy=1 is ignored and has no queueing effect.
- start in the same cycle as FIN is also ignored; a new scan can start on the first IDLE cycle.
- Changes to perm, neg, out_neg and exp_tt during a scan have no effect.
- tt, match and err hold their values after FIN until the next accepted start.

## Timing
- Reset values: x0..x3=0, busy=0, done=0, tt=16'h0000, match=0, err=0, state IDLE, m=0, h=0.
- start accepted at edge E:
  - busy=1 from E.
  - Minterm m is presented for SETTLE+1 cycles, starting E + m·(SETTLE+1).
  - y0 is sampled at the last edge of each minterm window.
  - done is high in the cycle beginning at edge E + 16·(SETTLE+1).
  - busy falls one cycle after done.
- Invalid perm: done is high in the cycle beginning at E+1, err=1, tt=0, match=0.
- Reset asserted mid-scan: all outputs return to their reset values immediately (asynchronous). No done pulse is produced. The block stays in IDLE after rst is released.
- Minimum start-to-start interval: 16·(SETTLE+1)+2 cycles.

## Test plan
- Identity transform: bench model y0=x0&x1, perm=8'hE4, neg=0, out_neg=0, exp_tt=16'h8888, SETTLE=0 -> done exactly 16 cycles after start, tt=16'h8888, match=1, err=0.
- Negation: same model, neg=4'b0001 -> tt=16'h4444. With neg=0 and out_neg=1 -> tt=16'h7777. For both cases, exp_tt=16'h8888 -> match=0.
- Permutation: perm=8'hC6 (x0<-m2, x2<-m0), y0=x0&x1 -> tt=16'hC0C0. Check x0..x3 each cycle against the mapping formula.
- Invalid perm: perm=8'h00 -> done one cycle after start, err=1, tt=0, match=0. A following valid scan clears err.
- Start during busy and reset mid-scan:
  - A second start in SCAN and in FIN is ignored; the latched config is unchanged.
  - rst asserted at minterm 7 -> outputs are 0 within the same cycle and no done pulse occurs.
  - A subsequent scan completes normally.
- SETTLE=2: each minterm is held 3 cycles, y0 is sampled only on the 3rd, and done arrives 48 cycles after start. A bench model with y0 delayed 2 cycles still yields tt=16'h8888.

Source files
------------

// File: rtl/npn_tt_scanner.sv
// Scans all 16 minterms of a 4-input function block through a latched NPN transform
// and assembles the response truth table for comparison against an expected table.
module npn_tt_scanner #(
    parameter int unsigned SETTLE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  perm,
    input  logic [3:0]  neg,
    input  logic        out_neg,
    input  logic [15:0] exp_tt,
    output logic        x0,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    input  logic        y0,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic        match,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  m_r;
    logic [3:0]  h_r;
    logic [7:0]  perm_r;
    logic [3:0]  neg_r;
    logic        out_neg_r;
    logic [15:0] exp_r;
    logic [3:0]  x_r;
    logic        busy_r;
    logic        done_r;
    logic [15:0] tt_r;
    logic        match_r;
    logic        err_r;

    logic        valid_s;
    logic        sample_s;
    logic        last_s;
    logic [15:0] tt_next_s;

    // All four 2-bit source indices must be distinct for a legal permutation.
    function automatic logic perm_valid(input logic [7:0] p);
        return (p[1:0] != p[3:2]) && (p[1:0] != p[5:4]) && (p[1:0] != p[7:6]) &&
               (p[3:2] != p[5:4]) && (p[3:2] != p[7:6]) && (p[5:4] != p[7:6]);
    endfunction

    function automatic logic [3:0] map_minterm(input logic [3:0] mt,
                                               input logic [7:0] p,
                                               input logic [3:0] n);
        logic [3:0] r;
        r = 4'd0;
        for (int j = 0; j < 4; j++) begin
            r[j] = mt[p[2*j +: 2]] ^ n[j];
        end
        return r;
    endfunction

    assign valid_s  = perm_valid(perm);
    assign sample_s = (state_r == SCAN) && (h_r == SETTLE_C);
    assign last_s   = sample_s && (m_r == 4'd15);

    // Truth table as it will look once the current minterm response is captured.
    always_comb begin
        tt_next_s      = tt_r;
        tt_next_s[m_r] = y0 ^ out_neg_r;
    end

    // Next-state logic; FIN lingers one extra cycle on the invalid-perm path so done lands at E+1.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = valid_s ? SCAN : FIN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (last_s) begin
                    state_s = FIN;
                end else begin
                    state_s = SCAN;
                end
            end
            FIN: begin
                if (done_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = FIN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: config latch, minterm/hold counters, stimulus and captured results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_r       <= 4'd0;
            h_r       <= 4'd0;
            perm_r    <= 8'd0;
            neg_r     <= 4'd0;
            out_neg_r <= 1'b0;
            exp_r     <= 16'd0;
            x_r       <= 4'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            tt_r      <= 16'd0;
            match_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        perm_r    <= perm;
                        neg_r     <= neg;
                        out_neg_r <= out_neg;
                        exp_r     <= exp_tt;
                        m_r       <= 4'd0;
                        h_r       <= 4'd0;
                        tt_r      <= 16'd0;
                        match_r   <= 1'b0;
                        err_r     <= ~valid_s;
                        busy_r    <= 1'b1;
                        x_r       <= valid_s ? map_minterm(4'd0, perm, neg) : 4'd0;
                    end
                end
                SCAN: begin
                    if (sample_s) begin
                        tt_r <= tt_next_s;
                        h_r  <= 4'd0;
                        m_r  <= m_r + 4'd1;
                        if (last_s) begin
                            x_r     <= 4'd0;
                            done_r  <= 1'b1;
                            match_r <= (tt_next_s == exp_r);
                        end else begin
                            x_r <= map_minterm(m_r + 4'd1, perm_r, neg_r);
                        end
                    end else begin
                        h_r <= h_r + 4'd1;
                    end
                end
                FIN: begin
                    if (done_r) begin
                        done_r <= 1'b0;
                        busy_r <= 1'b0;
                    end else begin
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    x_r    <= 4'd0;
                end
            endcase
        end
    end

    assign x0    = x_r[0];
    assign x1    = x_r[1];
    assign x2    = x_r[2];
    assign x3    = x_r[3];
    assign busy  = busy_r;
    assign done  = done_r;
    assign tt    = tt_r;
    assign match = match_r;
    assign err   = err_r;

endmodule

// File: tb/tb_npn_tt_scanner.sv
// Randomized and directed self-check of npn_tt_scanner against a truth-table reference model.
module tb_npn_tt_scanner;

    logic        clk;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic [7:0]  perm;
    logic [3:0]  neg;
    logic        out_neg;
    logic [15:0] exp_tt;
    logic [15:0] func_a;

    logic        x0_a, x1_a, x2_a, x3_a, y0_a, busy_a, done_a, match_a, err_a;
    logic [15:0] tt_a;
    logic        x0_b, x1_b, x2_b, x3_b, y0_b, busy_b, done_b, match_b, err_b;
    logic [15:0] tt_b;
    logic        d1_b, d2_b;
    logic [3:0]  xa;

    int n_checks = 0;
    int n_errors = 0;

    npn_tt_scanner #(.SETTLE(0)) u_dut (
        .clk(clk), .rst(rst), .start(start_a), .perm(perm), .neg(neg),
        .out_neg(out_neg), .exp_tt(exp_tt),
        .x0(x0_a), .x1(x1_a), .x2(x2_a), .x3(x3_a), .y0(y0_a),
        .busy(busy_a), .done(done_a), .tt(tt_a), .match(match_a), .err(err_a)
    );

    npn_tt_scanner #(.SETTLE(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .start(start_b), .perm(perm), .neg(neg),
        .out_neg(out_neg), .exp_tt(exp_tt),
        .x0(x0_b), .x1(x1_b), .x2(x2_b), .x3(x3_b), .y0(y0_b),
        .busy(busy_b), .done(done_b), .tt(tt_b), .match(match_b), .err(err_b)
    );

    assign xa   = {x3_a, x2_a, x1_a, x0_a};
    assign y0_a = func_a[xa];

    // Function block with two cycles of latency: y0 = x0 & x1 delayed.
    always @(posedge clk) begin
        d1_b <= x0_b & x1_b;
        d2_b <= d1_b;
    end
    assign y0_b = d2_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic perm_ok(input logic [7:0] p);
        logic [3:0] used;
        used = 4'd0;
        for (int j = 0; j < 4; j++) used[p[2*j +: 2]] = 1'b1;
        return used == 4'hF;
    endfunction

    // Input j of the function block takes minterm bit p[j], optionally inverted.
    function automatic logic [3:0] model_x(input int m, input logic [7:0] p, input logic [3:0] n);
        logic [3:0] mv;
        logic [3:0] r;
        mv = 4'(m);
        for (int j = 0; j < 4; j++) r[j] = mv[p[2*j +: 2]] ^ n[j];
        return r;
    endfunction

    function automatic logic [15:0] model_tt(input logic [7:0] p, input logic [3:0] n,
                                             input logic on, input logic [15:0] f);
        logic [15:0] r;
        for (int m = 0; m < 16; m++) r[m] = f[model_x(m, p, n)] ^ on;
        return r;
    endfunction

    // One scan on the SETTLE=0 instance; mode 1 also pokes start and config while busy.
    task automatic scan_a(input logic [7:0] p, input logic [3:0] n, input logic on,
                          input logic [15:0] e, input logic [15:0] f, input int mode);
        logic        ok;
        logic [15:0] want_tt;
        logic        want_match;
        int          want_lat;
        int          k;
        ok         = perm_ok(p);
        want_tt    = ok ? model_tt(p, n, on, f) : 16'h0000;
        want_match = ok && (want_tt == e);
        want_lat   = ok ? 16 : 1;
        @(negedge clk);
        perm = p; neg = n; out_neg = on; exp_tt = e; func_a = f; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = 0;
        while (!done_a && k < 60) begin
            if (ok && k < 16) check_value("x_map", 32'(xa), 32'(model_x(k, p, n)));
            check_value("busy_scan", 32'(busy_a), 32'd1);
            if (mode == 1 && ok && k == 5) begin
                start_a = 1'b1; perm = 8'($urandom); neg = 4'($urandom);
                out_neg = ~on; exp_tt = ~e;
            end
            if (k == 6) start_a = 1'b0;
            @(negedge clk);
            k++;
        end
        check_value("latency", 32'(k), 32'(want_lat));
        check_value("done", 32'(done_a), 32'd1);
        check_value("tt", 32'(tt_a), 32'(want_tt));
        check_value("match", 32'(match_a), 32'(want_match));
        check_value("err", 32'(err_a), 32'(!ok));
        check_value("busy_fin", 32'(busy_a), 32'd1);
        if (mode == 1) start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_value("done_gone", 32'(done_a), 32'd0);
        check_value("busy_gone", 32'(busy_a), 32'd0);
        check_value("tt_held", 32'(tt_a), 32'(want_tt));
        check_value("match_held", 32'(match_a), 32'(want_match));
        @(negedge clk);
        check_value("no_queue", 32'(busy_a), 32'd0);
    endtask

    initial begin
        logic [1:0]  arr [4];
        logic [1:0]  tmp;
        logic [7:0]  p;
        logic [15:0] f;
        logic [15:0] e;
        logic        on;
        int          k;
        int          ndone;
        int          sw;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; perm = 8'h00; neg = 4'h0;
        out_neg = 1'b0; exp_tt = 16'h0000; func_a = 16'h8888;
        repeat (2) @(negedge clk);
        check_value("rst_x", 32'(xa), 32'd0);
        check_value("rst_busy", 32'({busy_a, busy_b}), 32'd0);
        check_value("rst_done", 32'({done_a, done_b}), 32'd0);
        check_value("rst_tt", 32'(tt_a), 32'd0);
        check_value("rst_flags", 32'({match_a, err_a, match_b, err_b}), 32'd0);
        rst = 1'b0;

        scan_a(8'hE4, 4'b0000, 1'b0, 16'h8888, 16'h8888, 0);
        check_value("tt_ident", 32'(tt_a), 32'h8888);
        scan_a(8'hE4, 4'b0001, 1'b0, 16'h8888, 16'h8888, 0);
        check_value("tt_neg", 32'(tt_a), 32'h4444);
        scan_a(8'hE4, 4'b0000, 1'b1, 16'h8888, 16'h8888, 0);
        check_value("tt_outneg", 32'(tt_a), 32'h7777);
        scan_a(8'hC6, 4'b0000, 1'b0, 16'hC0C0, 16'h8888, 1);
        check_value("tt_perm", 32'(tt_a), 32'hC0C0);
        scan_a(8'h00, 4'b0000, 1'b0, 16'h8888, 16'h8888, 0);
        check_value("err_inv", 32'(err_a), 32'd1);
        scan_a(8'hE4, 4'b0000, 1'b0, 16'h8888, 16'h8888, 0);
        check_value("err_clear", 32'(err_a), 32'd0);

        // Reset while minterm 7 is presented.
        @(negedge clk);
        perm = 8'hE4; neg = 4'h0; out_neg = 1'b0; exp_tt = 16'h8888; func_a = 16'h8888;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (7) @(negedge clk);
        check_value("pre_rst_x", 32'(xa), 32'h7);
        check_value("pre_rst_tt", 32'(tt_a), 32'h0008);
        #2 rst = 1'b1;
        #1;
        check_value("mid_rst_x", 32'(xa), 32'd0);
        check_value("mid_rst_out", 32'({busy_a, done_a, match_a, err_a}), 32'd0);
        check_value("mid_rst_tt", 32'(tt_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_a || busy_a) ndone++;
        end
        check_value("post_rst_idle", 32'(ndone), 32'd0);
        scan_a(8'hE4, 4'b0000, 1'b0, 16'h8888, 16'h8888, 0);

        // SETTLE=2 instance against a two-cycle-latency function block.
        @(negedge clk);
        perm = 8'hE4; neg = 4'h0; out_neg = 1'b0; exp_tt = 16'h8888; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = 0;
        while (!done_b && k < 120) begin
            if (k < 48) check_value("x_s2", 32'({x3_b, x2_b, x1_b, x0_b}), 32'(k / 3));
            @(negedge clk);
            k++;
        end
        check_value("latency_s2", 32'(k), 32'd48);
        check_value("tt_s2", 32'(tt_b), 32'h8888);
        check_value("match_s2", 32'(match_b), 32'd1);
        @(negedge clk);
        check_value("busy_s2", 32'(busy_b), 32'd0);

        // Randomized transforms and functions.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                p = 8'($urandom);
            end else begin
                arr[0] = 2'd0; arr[1] = 2'd1; arr[2] = 2'd2; arr[3] = 2'd3;
                for (int i = 3; i > 0; i--) begin
                    sw = int'($urandom_range(0, i));
                    tmp = arr[i]; arr[i] = arr[sw]; arr[sw] = tmp;
                end
                p = {arr[3], arr[2], arr[1], arr[0]};
            end
            f  = 16'($urandom);
            on = 1'($urandom);
            e  = ($urandom_range(0, 1) == 0) ? model_tt(p, neg, on, f) : 16'($urandom);
            neg = 4'($urandom);
            if ($urandom_range(0, 1) == 0) e = model_tt(p, neg, on, f);
            scan_a(p, neg, on, e, f, (it % 5 == 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
